// File: rtl/sb_pkg.sv
// Shared definitions for the sb_* stream blocks.
//   sb_state_e : two-state word-holding FSM encoding (IDLE = empty, SEND = word held)
package sb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } sb_state_e;

endpackage

// File: rtl/sb_downsizer.sv
// sb_downsizer: splits one wide input word into up to RATIO narrow output beats.
// A word and its beat count (len_i + 1) are taken on the write handshake. Its beats
// are then presented low slice first, one per read handshake. The next word may be
// accepted in the same cycle the final beat is taken, so back-to-back words flow
// with no idle cycle.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   data_i     : input word, beat 0 in bits [OUT_WIDTH-1:0]
//   len_i      : beats in word minus one
//   wr_valid_i : producer offers data_i/len_i
//   wr_ready_o : block accepts a word this cycle
//   data_o     : current output beat
//   last_o     : data_o is the final beat of its word
//   rd_valid_i : consumer takes the current beat
//   rd_ready_o : data_o/last_o are valid
module sb_downsizer
    import sb_pkg::*;
#(
    parameter int unsigned   OUT_WIDTH = 8,
    parameter int unsigned   RATIO     = 4,
    localparam int unsigned  IN_WIDTH  = OUT_WIDTH * RATIO,
    localparam int unsigned  CNT_WIDTH = $clog2(RATIO)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  data_i,
    input  logic [CNT_WIDTH-1:0] len_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 last_o,
    input  logic                 rd_valid_i,
    output logic                 rd_ready_o
);

    sb_state_e state_q, state_d;
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic [RATIO-1:0][OUT_WIDTH-1:0] hold_q;

    logic at_last;
    logic rd_hs;
    logic wr_hs;

    assign at_last = (beat_cnt_q == len_q);

    // Gating with rst_n keeps all handshake outputs low while reset is held,
    // independent of whatever the state register holds before the first edge.
    assign rd_ready_o = rst_n & (state_q == SEND);
    assign rd_hs      = rd_valid_i & rd_ready_o;
    assign wr_ready_o = rst_n & ((state_q == IDLE) | (rd_hs & at_last));
    assign wr_hs      = wr_valid_i & wr_ready_o;

    assign data_o = hold_q[beat_cnt_q];
    assign last_o = rd_ready_o & at_last;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;

        case (state_q)
            IDLE: begin
                if (wr_hs) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (rd_hs) begin
                    if (!at_last) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end else if (!wr_hs) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // wr_hs can only occur in IDLE or while the final beat is taken; both
        // cases start a fresh word from beat 0.
        if (wr_hs) begin
            len_d      = len_i;
            beat_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
        end
    end

    // Data register carries no reset; wr_hs is already low during reset.
    always_ff @(posedge clk) begin
        if (wr_hs) begin
            hold_q <= data_i;
        end
    end

endmodule

// File: tb/tb_sb_downsizer.sv
module tb_sb_downsizer;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_i;
    logic [1:0]  len_i;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic [7:0]  data_o;
    logic        last_o;
    logic        rd_valid_i;
    logic        rd_ready_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Pending beats of the currently held word: {last, data}
    logic [8:0] mq[$];

    // Beats observed being taken
    logic [7:0] got_d[$];
    logic       got_l[$];
    logic       got_w[$];
    int         got_c[$];

    sb_downsizer #(
        .OUT_WIDTH (8),
        .RATIO     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_i     (data_i),
        .len_i      (len_i),
        .wr_valid_i (wr_valid_i),
        .wr_ready_o (wr_ready_o),
        .data_o     (data_o),
        .last_o     (last_o),
        .rd_valid_i (rd_valid_i),
        .rd_ready_o (rd_ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: a word becomes len+1 queued beats; one leaves per read handshake.
    always @(posedge clk) begin : model
        bit hs_r, hs_w;
        if (!rst_n) begin
            mq.delete();
        end else begin
            hs_r = rd_valid_i && (mq.size() > 0);
            hs_w = wr_valid_i && ((mq.size() == 0) || (rd_valid_i && mq.size() == 1));
            if (hs_r) void'(mq.pop_front());
            if (hs_w) begin
                for (int i = 0; i <= int'(len_i); i++) begin
                    mq.push_back({(i == int'(len_i)), 8'(data_i >> (8 * i))});
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic exp_rd, exp_wr;
        exp_rd = rst_n && (mq.size() > 0);
        exp_wr = rst_n && ((mq.size() == 0) || (rd_valid_i && mq.size() == 1));
        chk("wr_ready_o", 32'(wr_ready_o), 32'(exp_wr));
        chk("rd_ready_o", 32'(rd_ready_o), 32'(exp_rd));
        if (exp_rd) begin
            chk("data_o", 32'(data_o), 32'(mq[0][7:0]));
            chk("last_o", 32'(last_o), 32'(mq[0][8]));
        end else if (!rst_n) begin
            chk("last_o_in_reset", 32'(last_o), 32'd0);
        end
        if (rst_n && rd_valid_i && rd_ready_o) begin
            got_d.push_back(data_o);
            got_l.push_back(last_o);
            got_w.push_back(wr_ready_o);
            got_c.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got_d.delete();
        got_l.delete();
        got_w.delete();
        got_c.delete();
    endtask

    task automatic check_beat(input string nm, input int i, input logic [7:0] d, input logic l);
        if (i < got_d.size()) begin
            chk({nm, "_data"}, 32'(got_d[i]), 32'(d));
            chk({nm, "_last"}, 32'(got_l[i]), 32'(l));
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: beat %0d missing, got %0d beats", nm, i, got_d.size());
        end
    endtask

    task automatic check_consec(input string nm, input int n);
        for (int i = 1; i < n; i++) begin
            if (i < got_c.size()) chk(nm, 32'(got_c[i] - got_c[i-1]), 32'd1);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        wr_valid_i = 1'b0;
        rd_valid_i = 1'b0;
        data_i     = '0;
        len_i      = '0;
        step();
        step();
        @(negedge clk);
        chk("rst_wr_ready", 32'(wr_ready_o), 32'd0);
        chk("rst_rd_ready", 32'(rd_ready_o), 32'd0);
        chk("rst_last", 32'(last_o), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_wr_ready", 32'(wr_ready_o), 32'd1);
        step();

        // Single full word, consumer always ready
        clear_log();
        data_i = 32'h4433_2211; len_i = 2'd3; wr_valid_i = 1'b1; rd_valid_i = 1'b1;
        step();
        wr_valid_i = 1'b0;
        repeat (5) step();
        rd_valid_i = 1'b0;
        step();
        chk("t1_count", 32'(got_d.size()), 32'd4);
        check_beat("t1_b0", 0, 8'h11, 1'b0);
        check_beat("t1_b1", 1, 8'h22, 1'b0);
        check_beat("t1_b2", 2, 8'h33, 1'b0);
        check_beat("t1_b3", 3, 8'h44, 1'b1);
        check_consec("t1_consec", 4);

        // Back-to-back words, no bubble
        clear_log();
        data_i = 32'hDDCC_BBAA; len_i = 2'd3; wr_valid_i = 1'b1; rd_valid_i = 1'b1;
        step();
        data_i = 32'h0000_5566; len_i = 2'd1;
        repeat (4) step();
        wr_valid_i = 1'b0;
        repeat (2) step();
        rd_valid_i = 1'b0;
        step();
        chk("t2_count", 32'(got_d.size()), 32'd6);
        check_beat("t2_b0", 0, 8'hAA, 1'b0);
        check_beat("t2_b1", 1, 8'hBB, 1'b0);
        check_beat("t2_b2", 2, 8'hCC, 1'b0);
        check_beat("t2_b3", 3, 8'hDD, 1'b1);
        check_beat("t2_b4", 4, 8'h66, 1'b0);
        check_beat("t2_b5", 5, 8'h55, 1'b1);
        check_consec("t2_consec", 6);
        if (got_w.size() > 3) begin
            chk("t2_wr_ready_at_aa", 32'(got_w[0]), 32'd0);
            chk("t2_wr_ready_at_dd", 32'(got_w[3]), 32'd1);
        end

        // Single-beat word
        clear_log();
        data_i = 32'h0000_00EE; len_i = 2'd0; wr_valid_i = 1'b1; rd_valid_i = 1'b1;
        step();
        wr_valid_i = 1'b0;
        step();
        @(negedge clk);
        chk("t3_idle_wr_ready", 32'(wr_ready_o), 32'd1);
        chk("t3_idle_rd_ready", 32'(rd_ready_o), 32'd0);
        rd_valid_i = 1'b0;
        step();
        chk("t3_count", 32'(got_d.size()), 32'd1);
        check_beat("t3_b0", 0, 8'hEE, 1'b1);

        // Consumer stalls mid-word
        clear_log();
        data_i = 32'hA4A3_A2A1; len_i = 2'd3; wr_valid_i = 1'b1; rd_valid_i = 1'b0;
        step();
        wr_valid_i = 1'b0;
        begin
            bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
            for (int i = 0; i < 6; i++) begin
                rd_valid_i = pat[i];
                if (!pat[i]) begin
                    @(negedge clk);
                    chk("t4_stall_data", 32'(data_o), 32'h0000_00A2);
                    chk("t4_stall_wr_ready", 32'(wr_ready_o), 32'd0);
                end
                step();
            end
        end
        rd_valid_i = 1'b0;
        step();
        chk("t4_count", 32'(got_d.size()), 32'd4);
        check_beat("t4_b0", 0, 8'hA1, 1'b0);
        check_beat("t4_b1", 1, 8'hA2, 1'b0);
        check_beat("t4_b2", 2, 8'hA3, 1'b0);
        check_beat("t4_b3", 3, 8'hA4, 1'b1);
        if (got_w.size() > 3) begin
            chk("t4_wr_ready_b2", 32'(got_w[2]), 32'd0);
            chk("t4_wr_ready_b3", 32'(got_w[3]), 32'd1);
        end

        // Reset after two of four beats
        clear_log();
        data_i = 32'hB4B3_B2B1; len_i = 2'd3; wr_valid_i = 1'b1; rd_valid_i = 1'b0;
        step();
        wr_valid_i = 1'b0;
        rd_valid_i = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_in_rst_rd_ready", 32'(rd_ready_o), 32'd0);
        chk("t5_in_rst_wr_ready", 32'(wr_ready_o), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_after_rst_rd_ready", 32'(rd_ready_o), 32'd0);
        chk("t5_after_rst_wr_ready", 32'(wr_ready_o), 32'd1);
        repeat (3) step();
        data_i = 32'hC4C3_C2C1; len_i = 2'd3; wr_valid_i = 1'b1;
        step();
        wr_valid_i = 1'b0;
        repeat (4) step();
        rd_valid_i = 1'b0;
        step();
        chk("t5_count", 32'(got_d.size()), 32'd6);
        check_beat("t5_b0", 0, 8'hB1, 1'b0);
        check_beat("t5_b1", 1, 8'hB2, 1'b0);
        check_beat("t5_c0", 2, 8'hC1, 1'b0);
        check_beat("t5_c1", 3, 8'hC2, 1'b0);
        check_beat("t5_c2", 4, 8'hC3, 1'b0);
        check_beat("t5_c3", 5, 8'hC4, 1'b1);

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sb_downsizer.md
SB_DOWNSIZER -- requirements
Module: sb_downsizer

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 8, meaning the output beat width in bits.
REQ-002 SHALL have parameter RATIO, default 4, meaning the maximum number of output beats per input word; legal values are 2 or greater.
REQ-003 SHALL have derived parameter IN_WIDTH = OUT_WIDTH*RATIO, meaning the input word width (not user-set).
REQ-004 SHALL have derived parameter CNT_WIDTH = $clog2(RATIO), meaning the beat-counter and length width (not user-set).
REQ-005 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port data_i, input, IN_WIDTH bits: input word; beat 0 occupies bits [OUT_WIDTH-1:0].
REQ-008 SHALL have port len_i, input, CNT_WIDTH bits: beat count minus 1, so value k means k+1 beats.
REQ-009 SHALL have port wr_valid_i, input, 1 bit: the producer offers data_i/len_i.
REQ-010 SHALL have port wr_ready_o, output, 1 bit: the block can accept a word.
REQ-011 SHALL have port data_o, output, OUT_WIDTH bits: the current output beat.
REQ-012 SHALL have port last_o, output, 1 bit: data_o is the final beat of its word.
REQ-013 SHALL have port rd_valid_i, input, 1 bit: the consumer takes the current beat.
REQ-014 SHALL have port rd_ready_o, output, 1 bit: data_o/last_o are valid.

Function
REQ-015 SHALL define handshakes as wr_hs = wr_valid_i & wr_ready_o and rd_hs = rd_valid_i & rd_ready_o; no transfer occurs otherwise.
REQ-016 SHALL implement a 2-state FSM: IDLE (no word held) and SEND (word held, beats pending).
REQ-017 SHALL, in IDLE on wr_hs, latch data_i into hold_q and len_i into len_q, clear beat_cnt to 0, and go to SEND.
REQ-018 SHALL, in SEND on rd_hs with beat_cnt != len_q, increment beat_cnt and stay in SEND.
REQ-019 SHALL, in SEND on rd_hs with beat_cnt == len_q and wr_hs in the same cycle, reload hold_q/len_q, clear beat_cnt, and stay in SEND (no bubble).
REQ-020 SHALL, in SEND on rd_hs with beat_cnt == len_q and no wr_hs, go to IDLE.
REQ-021 SHALL drive rd_ready_o = (state == SEND), registered-state-derived with no combinational path from inputs.
REQ-022 SHALL drive wr_ready_o = (state == IDLE) | (rd_hs & beat_cnt == len_q); the combinational path rd_valid_i->wr_ready_o is permitted.
REQ-023 SHALL drive data_o = hold_q[beat_cnt*OUT_WIDTH +: OUT_WIDTH].
REQ-024 SHALL drive last_o = rd_ready_o & (beat_cnt == len_q).
REQ-025 SHALL present the first beat one cycle after its wr_hs and sustain one beat per cycle while rd_valid_i stays high, including across word boundaries.
REQ-026 SHALL leave data_o/last_o undefined while rd_ready_o is 0.
REQ-027 SHALL hold data_o/last_o stable while rd_ready_o is 1 and rd_valid_i is 0.
REQ-028 SHALL ignore wr_valid_i when wr_ready_o is 0 and rd_valid_i when rd_ready_o is 0.
REQ-029 SHALL send exactly 1 beat, with last_o asserted on it, when len_i = 0.
REQ-030 SHALL send RATIO beats when len_i = RATIO-1, with beat_cnt never exceeding len_q.

Reset
REQ-031 SHALL, while rst_n = 0 at a clock edge, set state to IDLE, beat_cnt to 0, and len_q to 0; hold_q is not reset.
REQ-032 SHALL force wr_ready_o = 0, rd_ready_o = 0, and last_o = 0 while rst_n = 0; wr_ready_o = 1 on the first cycle after release.
REQ-033 SHALL, on reset during SEND, discard the remaining beats of the held word; no beat of it appears after release.

Structure
REQ-034 SHALL take the state encoding constants (IDLE, SEND) from shared package sb_pkg, which other sb_* blocks reuse.
REQ-035 SHALL be a single flat module; no sub-module instance is required.

Verification
REQ-036 SHALL cover: OUT_WIDTH=8, RATIO=4, word 0x44332211 with len_i=3 and rd_valid_i held 1 -> data_o 0x11,0x22,0x33,0x44 on consecutive cycles, last_o only on 0x44.
REQ-037 SHALL cover: back-to-back words 0xDDCCBBAA (len 3) and 0x00005566 (len 1), wr_valid_i and rd_valid_i always 1 -> 6 beats in 6 consecutive cycles AA,BB,CC,DD,66,55, and wr_ready_o high in the cycle DD is taken.
REQ-038 SHALL cover: len_i=0 word 0x000000EE -> single beat 0xEE with last_o=1, then IDLE with wr_ready_o=1.
REQ-039 SHALL cover: rd_valid_i toggling 1,0,0,1 during a word -> data_o held through the stall cycles; no beat lost or duplicated; wr_ready_o=0 until the last beat is taken.
REQ-040 SHALL cover: rst_n low for 1 cycle after 2 of 4 beats are taken -> rd_ready_o=0 after reset, no remaining beats emitted, and the next word starts from beat 0.
